// File: rtl/button_pkg.sv
// Shared types and default constants for the push-button debouncer.
// Long-press detection is enabled with the macro BUTTON_LONG_PRESS_EN.
package button_pkg;

    // Debounce FSM states
    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } btn_state_e;

    // 1 ms at 100 MHz
    localparam int DEF_DEBOUNCE_CYCLES   = 100000;
    // 1 s at 100 MHz
    localparam int DEF_LONG_PRESS_CYCLES = 100000000;
    localparam int DEF_SYNC_STAGES       = 2;

    // Width of a counter that must reach n-1; never narrower than one bit
    function automatic int ctr_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Debounced level associated with each state
    function automatic logic state_is_held(input btn_state_e s);
        return (s == ST_PRESSED) || (s == ST_RELEASE_WAIT);
    endfunction

endpackage

// File: rtl/button_debounce_sync_ff.sv
// Multi-flop synchroniser bringing the raw button level into clk.
// Part of button_debounce (optional feature macro: BUTTON_LONG_PRESS_EN).
module sync_ff
    import button_pkg::*;
#(
    parameter int STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_chain;

    // Shift the asynchronous input through the flop chain
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], d};
        end
    end

    assign q = r_chain[STAGES-1];

endmodule

// File: rtl/button_debounce.sv
// Push-button debouncer with press/release pulses and debounced level.
// Define BUTTON_LONG_PRESS_EN to build the long-press hold counter.
module button_debounce
    import button_pkg::*;
#(
    parameter int SYNC_STAGES       = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES
) (
    input  logic clk_100mhz,
    input  logic rst_n_sync,
    input  logic button_in,
    output logic button_press_redge,
    output logic button_release_fedge,
    output logic button_level,
    output logic long_press
);

    localparam int CNT_W = ctr_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4 ||
        DEBOUNCE_CYCLES < 2 || LONG_PRESS_CYCLES < 2) begin : g_bad_cfg
        $error("button_debounce: parameter out of legal range");
    end

    btn_state_e       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_redge;
    logic             r_fedge;
    logic             r_level;

    logic w_btn_sync;
    logic w_cnt_done;
    logic w_press_accept;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk_100mhz),
        .rst_n (rst_n_sync),
        .d     (button_in),
        .q     (w_btn_sync)
    );

    assign w_cnt_done = (r_cnt == CNT_LAST);

    assign w_press_accept = (r_state == ST_PRESS_WAIT) &&
                            w_btn_sync && w_cnt_done;

    // Debounce FSM with its stability counter and registered outputs
    always_ff @(posedge clk_100mhz) begin
        if (!rst_n_sync) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_redge <= 1'b0;
            r_fedge <= 1'b0;
            r_level <= 1'b0;
        end else begin
            r_redge <= 1'b0;
            r_fedge <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_btn_sync) begin
                        r_state <= ST_PRESS_WAIT;
                        r_cnt   <= '0;
                    end
                end
                ST_PRESS_WAIT: begin
                    if (!w_btn_sync) begin
                        r_state <= ST_IDLE;
                    end else if (w_cnt_done) begin
                        r_state <= ST_PRESSED;
                        r_redge <= 1'b1;
                        r_level <= state_is_held(ST_PRESSED);
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_PRESSED: begin
                    if (!w_btn_sync) begin
                        r_state <= ST_RELEASE_WAIT;
                        r_cnt   <= '0;
                    end
                end
                ST_RELEASE_WAIT: begin
                    if (w_btn_sync) begin
                        r_state <= ST_PRESSED;
                    end else if (w_cnt_done) begin
                        r_state <= ST_IDLE;
                        r_fedge <= 1'b1;
                        r_level <= state_is_held(ST_IDLE);
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_level <= 1'b0;
                end
            endcase
        end
    end

    assign button_press_redge   = r_redge;
    assign button_release_fedge = r_fedge;
    assign button_level         = r_level;

`ifdef BUTTON_LONG_PRESS_EN
    localparam int HOLD_W = ctr_width(LONG_PRESS_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

    logic [HOLD_W-1:0] r_hold;
    logic              r_hold_done;
    logic              r_long;
    logic              w_held;

    assign w_held = state_is_held(r_state);

    // Hold timer: restarts on each accepted press, saturates after one pulse
    always_ff @(posedge clk_100mhz) begin
        if (!rst_n_sync) begin
            r_hold      <= '0;
            r_hold_done <= 1'b0;
            r_long      <= 1'b0;
        end else begin
            r_long <= 1'b0;
            if (w_press_accept) begin
                r_hold      <= '0;
                r_hold_done <= 1'b0;
            end else if (w_held && !r_hold_done) begin
                if (r_hold == HOLD_LAST) begin
                    r_long      <= 1'b1;
                    r_hold_done <= 1'b1;
                end else begin
                    r_hold <= r_hold + HOLD_W'(1);
                end
            end
        end
    end

    assign long_press = r_long;
`else
    logic w_unused_accept;
    assign w_unused_accept = w_press_accept;
    assign long_press      = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Self-checking bench for button_debounce (SYNC=2, DEBOUNCE=8, LONG=20).
// Long-press expectations follow whether BUTTON_LONG_PRESS_EN is defined.
module tb_button_debounce;

    localparam int SYNC = 2;
    localparam int DEB  = 8;
    localparam int LONG = 20;
`ifdef BUTTON_LONG_PRESS_EN
    localparam bit LP = 1'b1;
`else
    localparam bit LP = 1'b0;
`endif

    logic clk_100mhz;
    logic rst_n_sync;
    logic button_in;
    logic button_press_redge;
    logic button_release_fedge;
    logic button_level;
    logic long_press;

    int checks   = 0;
    int failures = 0;

    button_debounce #(
        .SYNC_STAGES       (SYNC),
        .DEBOUNCE_CYCLES   (DEB),
        .LONG_PRESS_CYCLES (LONG)
    ) dut (
        .clk_100mhz           (clk_100mhz),
        .rst_n_sync           (rst_n_sync),
        .button_in            (button_in),
        .button_press_redge   (button_press_redge),
        .button_release_fedge (button_release_fedge),
        .button_level         (button_level),
        .long_press           (long_press)
    );

    initial clk_100mhz = 1'b0;
    always #5 clk_100mhz = ~clk_100mhz;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: button_in delay line plus run-length rule.
    // A level change is accepted once the synchronised input has
    // disagreed with the debounced level for DEB+1 consecutive edges.
    bit m_q[$];
    int m_run;
    int m_age;
    bit m_lvl;
    bit m_re;
    bit m_fe;
    bit m_lp;

    function automatic void model_edge(input bit rst, input bit b);
        bit s;
        m_re = 1'b0;
        m_fe = 1'b0;
        m_lp = 1'b0;
        if (!rst) begin
            m_q.delete();
            repeat (SYNC) m_q.push_back(1'b0);
            m_lvl = 1'b0;
            m_run = 0;
            m_age = 0;
            return;
        end
        s = m_q.pop_front();
        m_q.push_back(b);
        if (m_lvl) begin
            m_age++;
            if (LP && m_age == LONG) m_lp = 1'b1;
        end
        if (s != m_lvl) m_run++;
        else m_run = 0;
        if (m_run == DEB + 1) begin
            m_lvl = s;
            m_run = 0;
            if (s) begin
                m_re  = 1'b1;
                m_age = 0;
            end else begin
                m_fe = 1'b1;
            end
        end
    endfunction

    task automatic chk_i(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s: got %0d want %0d at t=%0t",
                         name, act, exp, $time);
        end
    endtask

    task automatic chk_b(input string name, input logic act, input bit exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s: got %b want %b at t=%0t",
                         name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance the model, compare after the edge
    task automatic step(input bit rst, input bit b);
        rst_n_sync = rst;
        button_in  = b;
        @(posedge clk_100mhz);
        model_edge(rst, b);
        #1;
        chk_b("model redge", button_press_redge, m_re);
        chk_b("model fedge", button_release_fedge, m_fe);
        chk_b("model level", button_level, m_lvl);
        chk_b("model long", long_press, m_lp);
    endtask

    typedef struct {
        bit rst;
        bit btn;
        int cyc;
        int re_at;
        int fe_at;
        int lp_at;
        bit lvl;
    } seg_t;

    seg_t tbl[$];

    function automatic void add(input bit rst, input bit btn, input int cyc,
                                input int re, input int fe, input int lp,
                                input bit lvl);
        seg_t s;
        s.rst   = rst;
        s.btn   = btn;
        s.cyc   = cyc;
        s.re_at = re;
        s.fe_at = fe;
        s.lp_at = lp;
        s.lvl   = lvl;
        tbl.push_back(s);
    endfunction

    initial begin
        int re_pos, fe_pos, lp_pos;
        int re_n, fe_n, lp_n;

        rst_n_sync = 1'b0;
        button_in  = 1'b0;

        add(0, 0, 3, -1, -1, -1, 0);
        add(1, 1, 12, 10, -1, -1, 1);
        add(1, 1, 30, -1, -1, LP ? 18 : -1, 1);
        add(1, 0, 12, -1, 10, -1, 0);
        for (int k = 0; k < 4; k++) begin
            add(1, 1, 3, -1, -1, -1, 0);
            add(1, 0, 2, -1, -1, -1, 0);
        end
        add(1, 0, 12, -1, -1, -1, 0);
        add(1, 1, 12, 10, -1, -1, 1);
        add(1, 0, 5, -1, -1, -1, 1);
        add(1, 1, 12, -1, -1, -1, 1);
        add(0, 1, 2, -1, -1, -1, 0);
        add(1, 1, 12, 10, -1, -1, 1);
        add(1, 0, 12, -1, 10, -1, 0);
        add(1, 1, 8, -1, -1, -1, 0);
        add(1, 0, 4, -1, -1, -1, 0);
        add(1, 1, 9, -1, -1, -1, 0);
        add(1, 0, 12, 1, 10, -1, 0);

        foreach (tbl[i]) begin
            re_pos = -1; fe_pos = -1; lp_pos = -1;
            re_n = 0; fe_n = 0; lp_n = 0;
            for (int j = 0; j < tbl[i].cyc; j++) begin
                step(tbl[i].rst, tbl[i].btn);
                if (button_press_redge === 1'b1) begin
                    re_n++;
                    if (re_pos < 0) re_pos = j;
                end
                if (button_release_fedge === 1'b1) begin
                    fe_n++;
                    if (fe_pos < 0) fe_pos = j;
                end
                if (long_press === 1'b1) begin
                    lp_n++;
                    if (lp_pos < 0) lp_pos = j;
                end
            end
            chk_i($sformatf("seg%0d redge pos", i), re_pos, tbl[i].re_at);
            chk_i($sformatf("seg%0d redge n", i), re_n, tbl[i].re_at >= 0);
            chk_i($sformatf("seg%0d fedge pos", i), fe_pos, tbl[i].fe_at);
            chk_i($sformatf("seg%0d fedge n", i), fe_n, tbl[i].fe_at >= 0);
            chk_i($sformatf("seg%0d long pos", i), lp_pos, tbl[i].lp_at);
            chk_i($sformatf("seg%0d long n", i), lp_n, tbl[i].lp_at >= 0);
            chk_b($sformatf("seg%0d level", i), button_level, tbl[i].lvl);
        end

        for (int n = 0; n < 200; n++) begin
            int len;
            bit b;
            bit r;
            r = ($urandom_range(0, 40) != 0);
            b = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       len = $urandom_range(1, 4);
                1:       len = $urandom_range(7, 11);
                2:       len = $urandom_range(20, 45);
                default: len = $urandom_range(1, 15);
            endcase
            if (!r) len = $urandom_range(1, 2);
            for (int j = 0; j < len; j++) step(r, b);
        end

        for (int j = 0; j < 14; j++) step(1'b1, 1'b0);
        chk_b("final level", button_level, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
